// File: rtl/bht_alloc_ctrl.sv
// Purpose: fetch-stage prediction merge plus victim selection and allocation for taken BHT misses.
// Latency: predictions are combinational; WriteRow pulses ROWS+1 edges after the request edge.
// Backpressure: none upstream; one pending slot, overflow and updates lost during WRITE count into Drop_Cnt.
module bht_alloc_ctrl #(
  parameter int ROWS = 8,
  parameter int TAGW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          EX_PC,
  input  logic                 EX_Branch,
  input  logic                 Branch_Success,
  input  logic [31:0]          EX_Target,
  input  logic [ROWS*16-1:0]   Row_Count,
  input  logic [ROWS-1:0]      Row_EX_Hit,
  input  logic [ROWS-1:0]      Row_IF_Hit,
  input  logic [ROWS*32-1:0]   Row_Data,
  input  logic [ROWS-1:0]      Row_Pred,
  output logic [ROWS-1:0]      WriteRow,
  output logic [31:0]          Row_EX_PC,
  output logic [31:0]          Row_Data_In,
  output logic                 Row_EX_Branch,
  output logic                 Row_Branch_Success,
  output logic                 Pred_Jump,
  output logic [31:0]          Pred_Target,
  output logic                 Busy,
  output logic [15:0]          Drop_Cnt
);

  localparam int IW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WRITE = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_pc, r_tgt, r_pend_pc, r_pend_tgt;
  logic            r_pend_vld;
  logic [IW-1:0]   r_idx, r_best_idx, r_smp_idx;
  logic [15:0]     r_best_cnt, r_smp_cnt, r_drop_cnt;
  logic            r_smp_vld, r_smp_last;

  logic            w_req, w_dup_cur, w_dup_pend, w_new;
  logic            w_scan_end, w_launch_pend, w_launch_new, w_launch;
  logic            w_pend_store, w_drop_alloc, w_drop_upd;
  logic [15:0]     w_cnt_sel, w_drop_nxt;
  logic [16:0]     w_drop_sum;
  logic [31:0]     w_tgt_or;
  logic [ROWS-1:0] w_onehot;

  // Row_Pred is already IF-gated; the AND just keeps that qualification explicit here.
  assign Pred_Jump   = |(Row_Pred & Row_IF_Hit);
  assign Pred_Target = w_tgt_or;
  assign Drop_Cnt    = r_drop_cnt;

  // Missing rows present zero data, so an OR across lanes selects the hitting target.
  always_comb begin
    w_tgt_or = '0;
    for (int i = 0; i < ROWS; i++) w_tgt_or = w_tgt_or | Row_Data[i*32 +: 32];
  end

  // A duplicate tag (in flight or waiting) is dropped silently, not counted.
  assign w_req      = EX_Branch & Branch_Success & ~(|Row_EX_Hit);
  assign w_dup_cur  = (r_state != IDLE) && (EX_PC[TAGW-1:0] == r_pc[TAGW-1:0]);
  assign w_dup_pend = r_pend_vld && (EX_PC[TAGW-1:0] == r_pend_pc[TAGW-1:0]);
  assign w_new      = w_req & ~w_dup_cur & ~w_dup_pend;

  // The row count is registered before the compare, so the scan ends one edge after the last row is sampled.
  assign w_cnt_sel     = Row_Count[int'(r_idx)*16 +: 16];
  assign w_scan_end    = (r_state == SCAN) && r_smp_vld && r_smp_last;
  assign w_launch_pend = r_pend_vld && ((r_state == IDLE) || (r_state == WRITE));
  assign w_launch_new  = (r_state == IDLE) && !r_pend_vld && w_new;
  assign w_launch      = w_launch_pend | w_launch_new;
  assign w_pend_store  = w_new && (w_launch_pend || ((r_state != IDLE) && !r_pend_vld));
  assign w_drop_alloc  = w_new && (r_state == SCAN) && r_pend_vld;
  assign w_drop_upd    = (r_state == WRITE) && EX_Branch;
  assign w_onehot      = ROWS'(1) << r_best_idx;

  // Both loss sources may land in one cycle; the sum saturates instead of wrapping.
  assign w_drop_sum = {1'b0, r_drop_cnt} + {16'b0, w_drop_alloc} + {16'b0, w_drop_upd};
  assign w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and row-side outputs; rows see the live EX branch except during WRITE.
  always_comb begin
    w_state_nxt        = r_state;
    WriteRow           = '0;
    Busy               = 1'b0;
    Row_EX_PC          = EX_PC;
    Row_Data_In        = EX_Target;
    Row_EX_Branch      = EX_Branch;
    Row_Branch_Success = Branch_Success;
    case (r_state)
      IDLE: begin
        if (w_launch) w_state_nxt = SCAN;
      end
      SCAN: begin
        Busy = 1'b1;
        if (w_scan_end) w_state_nxt = WRITE;
      end
      WRITE: begin
        Busy               = 1'b1;
        WriteRow           = w_onehot;
        Row_EX_PC          = r_pc;
        Row_Data_In        = r_tgt;
        Row_EX_Branch      = 1'b1;
        Row_Branch_Success = 1'b1;
        w_state_nxt        = r_pend_vld ? SCAN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture, victim scan, pending slot and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= '0;
      r_tgt      <= '0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
      r_smp_idx  <= '0;
      r_smp_cnt  <= '0;
      r_smp_vld  <= 1'b0;
      r_smp_last <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
      r_pend_tgt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_launch_pend) begin
        r_pc  <= r_pend_pc;
        r_tgt <= r_pend_tgt;
      end else if (w_launch_new) begin
        r_pc  <= EX_PC;
        r_tgt <= EX_Target;
      end
      if (w_launch) begin
        r_idx      <= '0;
        r_best_idx <= '0;
        r_best_cnt <= '0;
        r_smp_vld  <= 1'b0;
        r_smp_last <= 1'b0;
      end else if (r_state == SCAN) begin
        // Strictly greater: ties keep the lower index, invalid rows win through bit 15.
        if (r_smp_vld && (r_smp_cnt > r_best_cnt)) begin
          r_best_cnt <= r_smp_cnt;
          r_best_idx <= r_smp_idx;
        end
        if (w_scan_end) begin
          r_smp_vld <= 1'b0;
        end else begin
          r_smp_vld  <= 1'b1;
          r_smp_cnt  <= w_cnt_sel;
          r_smp_idx  <= r_idx;
          r_smp_last <= (r_idx == IW'(ROWS-1));
          r_idx      <= r_idx + IW'(1);
        end
      end
      if (w_pend_store) begin
        r_pend_vld <= 1'b1;
        r_pend_pc  <= EX_PC;
        r_pend_tgt <= EX_Target;
      end else if (w_launch_pend) begin
        r_pend_vld <= 1'b0;
      end
      r_drop_cnt <= w_drop_nxt;
    end
  end

endmodule
